// File: rtl/mem_scan_pkg.sv
// Shared types and constants for the memory scan controller.
package mem_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    CHECK,
    DONE
  } state_t;

  localparam int ERR_WIDTH         = 16;
  localparam int DEFAULT_ADDRWIDTH = 8;
  localparam int DEFAULT_DATAWIDTH = 16;

endpackage

// File: rtl/mem_scan_if.sv
// Host/RAM-side signal bundle of the memory scan controller.
// master = controller view, slave = environment (host + RAM) view.
interface mem_scan_if
  import mem_scan_pkg::*;
#(
  parameter int ADDRWIDTH = DEFAULT_ADDRWIDTH,
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH
);

  logic                 iStart;
  logic [DATAWIDTH-1:0] iSeed;
  logic                 oWR;
  logic [ADDRWIDTH-1:0] oAddress;
  logic [DATAWIDTH-1:0] oWriteData;
  logic [DATAWIDTH-1:0] iReadData;
  logic                 oBusy;
  logic                 oDone;
  logic                 oPass;
  logic [ERR_WIDTH-1:0] oErrCount;
  logic [ADDRWIDTH-1:0] oFailAddr;

  modport master (
    input  iStart, iSeed, iReadData,
    output oWR, oAddress, oWriteData, oBusy, oDone, oPass, oErrCount, oFailAddr
  );

  modport slave (
    output iStart, iSeed, iReadData,
    input  oWR, oAddress, oWriteData, oBusy, oDone, oPass, oErrCount, oFailAddr
  );

endinterface

// File: rtl/mem_scan_checker.sv
// Read-back comparator: delays each presented read address by one cycle to meet the
// RAM's read latency, counts mismatches (saturating) and keeps the first failing address.
module mem_scan_checker
  import mem_scan_pkg::*;
#(
  parameter int ADDRWIDTH = DEFAULT_ADDRWIDTH,
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 sample,
  input  logic [ADDRWIDTH-1:0] addr,
  input  logic [DATAWIDTH-1:0] expected,
  input  logic [DATAWIDTH-1:0] read_data,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic [ADDRWIDTH-1:0] fail_addr
);

  localparam logic [ERR_WIDTH-1:0] ERR_STEP = ERR_WIDTH'(1);

  logic                 pend;
  logic [ADDRWIDTH-1:0] pend_addr;
  logic [DATAWIDTH-1:0] pend_expected;
  logic                 mismatch;

  assign mismatch = pend && (read_data != pend_expected);

  // NOTE: non-blocking assignments make every register here update from pre-edge values,
  // so the compare below sees last cycle's pend_* regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend          <= 1'b0;
      pend_addr     <= '0;
      pend_expected <= '0;
      err_count     <= '0;
      fail_addr     <= '0;
    end else begin
      pend          <= sample && !clear;
      pend_addr     <= addr;
      pend_expected <= expected;
      if (clear) begin
        err_count <= '0;
        fail_addr <= '0;
      end else if (mismatch) begin
        if (err_count != '1) err_count <= err_count + ERR_STEP;
        // A zero count can only mean no mismatch yet in this run, since it saturates.
        if (err_count == '0) fail_addr <= pend_addr;
      end
    end
  end

endmodule

// File: rtl/mem_scan_ctrl.sv
// Memory scan controller: writes zext(address) XOR seed over the whole RAM, reads it back
// and reports mismatches. Define MEMSCAN_INVERSE_PASS_EN to add a bit-inverted second pass.
module mem_scan_ctrl
  import mem_scan_pkg::*;
#(
  parameter int ADDRWIDTH = DEFAULT_ADDRWIDTH,
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH
) (
  input logic        iClk,
  input logic        iRst,
  mem_scan_if.master bus
);

  localparam logic [ADDRWIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDRWIDTH-1:0] ADDR_STEP = ADDRWIDTH'(1);

  state_t               state;
  logic [DATAWIDTH-1:0] seed;
  logic                 drain;
  logic                 accept;
  logic                 reading;
  logic [ADDRWIDTH-1:0] next_addr;
  logic [DATAWIDTH-1:0] read_expected;
  logic [ERR_WIDTH-1:0] err_count;
  logic [ADDRWIDTH-1:0] fail_addr;

`ifdef MEMSCAN_INVERSE_PASS_EN
  logic inv_pass;
`else
  localparam logic inv_pass = 1'b0;
`endif

  function automatic logic [DATAWIDTH-1:0] pattern(input logic [ADDRWIDTH-1:0] addr,
                                                   input logic [DATAWIDTH-1:0] base,
                                                   input logic                 inv);
    logic [DATAWIDTH-1:0] p;
    p = DATAWIDTH'(addr) ^ base;
    return inv ? ~p : p;
  endfunction

  assign accept        = bus.iStart && (state == IDLE || state == DONE);
  assign reading       = (state == READ);
  assign next_addr     = bus.oAddress + ADDR_STEP;
  assign read_expected = pattern(bus.oAddress, seed, inv_pass);
  assign bus.oErrCount = err_count;
  assign bus.oFailAddr = fail_addr;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state          <= IDLE;
      seed           <= '0;
      drain          <= 1'b0;
`ifdef MEMSCAN_INVERSE_PASS_EN
      inv_pass       <= 1'b0;
`endif
      bus.oWR        <= 1'b0;
      bus.oAddress   <= '0;
      bus.oWriteData <= '0;
      bus.oBusy      <= 1'b0;
      bus.oDone      <= 1'b0;
      bus.oPass      <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.iStart) begin
            state          <= WRITE;
            seed           <= bus.iSeed;
            drain          <= 1'b0;
`ifdef MEMSCAN_INVERSE_PASS_EN
            inv_pass       <= 1'b0;
`endif
            bus.oWR        <= 1'b1;
            bus.oAddress   <= '0;
            bus.oWriteData <= pattern('0, bus.iSeed, 1'b0);
            bus.oBusy      <= 1'b1;
            bus.oDone      <= 1'b0;
            bus.oPass      <= 1'b0;
          end
        end
        WRITE: begin
          if (bus.oAddress == LAST_ADDR) begin
            state          <= READ;
            bus.oWR        <= 1'b0;
            bus.oAddress   <= '0;
            bus.oWriteData <= '0;
          end else begin
            bus.oAddress   <= next_addr;
            bus.oWriteData <= pattern(next_addr, seed, inv_pass);
          end
        end
        READ: begin
          if (bus.oAddress == LAST_ADDR) begin
            state        <= CHECK;
            bus.oAddress <= '0;
          end else begin
            bus.oAddress <= next_addr;
          end
        end
        CHECK: begin
`ifdef MEMSCAN_INVERSE_PASS_EN
          if (!inv_pass) begin
            // The last normal-pass compare still lands in the first inverted WRITE cycle.
            state          <= WRITE;
            inv_pass       <= 1'b1;
            bus.oWR        <= 1'b1;
            bus.oAddress   <= '0;
            bus.oWriteData <= pattern('0, seed, 1'b1);
          end else
`endif
          if (!drain) begin
            // Extra cycle lets the final read-back compare settle before pass/fail is sampled.
            drain <= 1'b1;
          end else begin
            state     <= DONE;
            drain     <= 1'b0;
            bus.oBusy <= 1'b0;
            bus.oDone <= 1'b1;
            bus.oPass <= (err_count == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_scan_checker #(
    .ADDRWIDTH(ADDRWIDTH),
    .DATAWIDTH(DATAWIDTH)
  ) u_checker (
    .clk      (iClk),
    .rst      (iRst),
    .clear    (accept),
    .sample   (reading),
    .addr     (bus.oAddress),
    .expected (read_expected),
    .read_data(bus.iReadData),
    .err_count(err_count),
    .fail_addr(fail_addr)
  );

endmodule

// File: tb/tb_mem_scan_ctrl.sv
// Bench for mem_scan_ctrl: behavioural RAM with fault injection, a timeline model of a scan
// checked every cycle, and directed scenarios pinned by hand-computed results.
module tb_mem_scan_ctrl;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int N  = 1 << AW;
`ifdef MEMSCAN_INVERSE_PASS_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif
  localparam int PASSES   = INV ? 2 : 1;
  localparam int DONE_T   = INV ? 4 * N + 3 : 2 * N + 2;
  localparam int DONE_CYC = INV ? 1027 : 514;

  logic iClk = 1'b0;
  logic iRst;

  mem_scan_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) bus ();

  mem_scan_ctrl #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) dut (
    .iClk(iClk),
    .iRst(iRst),
    .bus (bus.master)
  );

  always #5 iClk = ~iClk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- RAM model with per-pass read fault injection ----------------
  logic [DW-1:0] mem  [N];
  logic [DW-1:0] flip [N];
  int            fault_pass = 0;   // 0: every pass, otherwise only that pass number
  int            ram_wpass  = 0;   // which write pass the RAM has seen (address-0 writes)
  logic [DW-1:0] w3_data    = '0;  // pass-1 write to address 3
  logic [DW-1:0] p2w0_data  = '0;  // pass-2 write to address 0

  always @(posedge iClk) begin
    if (!iRst) begin
      if (bus.iStart && !bus.oBusy) ram_wpass <= 0;
      else if (bus.oWR && bus.oAddress == '0) ram_wpass <= ram_wpass + 1;
      if (bus.oWR) begin
        mem[bus.oAddress] <= bus.oWriteData;
        if (bus.oAddress == 8'h03 && ram_wpass == 1) w3_data <= bus.oWriteData;
        if (bus.oAddress == 8'h00 && ram_wpass == 1) p2w0_data <= bus.oWriteData;
      end
      bus.iReadData <= mem[bus.oAddress] ^
                       ((fault_pass == 0 || fault_pass == ram_wpass) ? flip[bus.oAddress] : '0);
    end
  end

  // ---------------- Scan model: phase + cycle index since the start edge ----------------
  typedef enum {M_IDLE, M_RUN, M_DONE} mphase_t;
  mphase_t       m_phase = M_IDLE;
  int            m_t     = 0;
  logic [DW-1:0] m_seed  = '0;
  int            m_err   = 0;
  int            m_fail  = 0;

  task automatic predict();
    m_err  = 0;
    m_fail = 0;
    for (int p = 1; p <= PASSES; p++)
      for (int a = 0; a < N; a++)
        if (flip[a] != '0 && (fault_pass == 0 || fault_pass == p)) begin
          if (m_err == 0) m_fail = a;
          m_err++;
        end
  endtask

  always @(posedge iClk) begin
    if (iRst) m_phase = M_IDLE;
    else if (m_phase != M_RUN && bus.iStart) begin
      m_phase = M_RUN;
      m_t     = 0;
      m_seed  = bus.iSeed;
      predict();
    end else if (m_phase == M_RUN) begin
      m_t++;
      if (m_t == DONE_T) m_phase = M_DONE;
    end
  end

  // kind: 0 write, 1 read, 2 check
  task automatic segment(input int t, output int kind, output int a, output bit inv);
    inv  = 1'b0;
    a    = 0;
    kind = 2;
    if (t < N) begin kind = 0; a = t; end
    else if (t < 2 * N) begin kind = 1; a = t - N; end
    else if (INV && t > 2 * N && t < 3 * N + 1) begin kind = 0; a = t - 2 * N - 1; inv = 1'b1; end
    else if (INV && t >= 3 * N + 1 && t < 4 * N + 1) begin kind = 1; a = t - 3 * N - 1; end
  endtask

  always @(negedge iClk) begin
    int            kind, a;
    bit            inv;
    logic [DW-1:0] pat;
    if (!iRst) begin
      case (m_phase)
        M_IDLE: begin
          check("idle_busy", bus.oBusy, 0);
          check("idle_done", bus.oDone, 0);
          check("idle_wr", bus.oWR, 0);
          check("idle_addr", bus.oAddress, 0);
          check("idle_wdata", bus.oWriteData, 0);
          check("idle_pass", bus.oPass, 0);
          check("idle_err", bus.oErrCount, 0);
          check("idle_fail", bus.oFailAddr, 0);
        end
        M_RUN: begin
          segment(m_t, kind, a, inv);
          check("run_busy", bus.oBusy, 1);
          check("run_done", bus.oDone, 0);
          check("run_wr", bus.oWR, (kind == 0) ? 1 : 0);
          if (kind != 2) check("run_addr", bus.oAddress, a);
          if (kind == 0) begin
            pat = DW'(a) ^ m_seed;
            check("run_wdata", bus.oWriteData, inv ? ~pat : pat);
          end
          if (m_t < N) begin
            check("run_err_clear", bus.oErrCount, 0);
            check("run_fail_clear", bus.oFailAddr, 0);
          end
        end
        default: begin
          check("done_busy", bus.oBusy, 0);
          check("done_done", bus.oDone, 1);
          check("done_wr", bus.oWR, 0);
          check("done_addr", bus.oAddress, 0);
          check("done_wdata", bus.oWriteData, 0);
          check("done_err", bus.oErrCount, m_err);
          check("done_fail", bus.oFailAddr, m_fail);
          check("done_pass", bus.oPass, (m_err == 0) ? 1 : 0);
        end
      endcase
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic clear_faults();
    for (int i = 0; i < N; i++) flip[i] = '0;
    fault_pass = 0;
  endtask

  task automatic start_run(input logic [DW-1:0] seed, input bit hold);
    @(posedge iClk);
    #1;
    bus.iSeed  = seed;
    bus.iStart = 1'b1;
    @(posedge iClk);
    #1;
    if (!hold) bus.iStart = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge iClk);
      #1;
      n++;
    end while (!bus.oDone && n < 4 * DONE_CYC);
    check("done_seen", bus.oDone, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clear_faults();
    iRst       = 1'b1;
    bus.iStart = 1'b0;
    bus.iSeed  = '0;
    repeat (3) @(posedge iClk);
    #1;
    check("rst_busy", bus.oBusy, 0);
    check("rst_err", bus.oErrCount, 0);
    iRst = 1'b0;
    repeat (3) @(posedge iClk);

    // Clean RAM, zero seed: data == address, pass.
    start_run(16'h0000, 1'b0);
    wait_done(n);
    check("t1_done_cycle", n, DONE_CYC);
    check("t1_pass", bus.oPass, 1);
    check("t1_err", bus.oErrCount, 0);
    check("t1_fail", bus.oFailAddr, 0);

    // Seed A5A5: address 3 carries A5A6.
    start_run(16'hA5A5, 1'b0);
    wait_done(n);
    check("t2_w3_data", w3_data, 16'hA5A6);
    check("t2_pass", bus.oPass, 1);

    // Bit-0 read faults at 05 and 80.
    flip[8'h05] = 16'h0001;
    flip[8'h80] = 16'h0001;
    start_run(16'h1234, 1'b0);
    wait_done(n);
    check("t3_err", bus.oErrCount, INV ? 4 : 2);
    check("t3_fail", bus.oFailAddr, 8'h05);
    check("t3_pass", bus.oPass, 0);
    clear_faults();

    // Asynchronous reset in the middle of READ.
    start_run(16'h00FF, 1'b0);
    repeat (299) @(posedge iClk);
    #2;
    iRst = 1'b1;
    #1;
    check("t4_rst_busy", bus.oBusy, 0);
    check("t4_rst_wr", bus.oWR, 0);
    check("t4_rst_addr", bus.oAddress, 0);
    check("t4_rst_wdata", bus.oWriteData, 0);
    check("t4_rst_done", bus.oDone, 0);
    check("t4_rst_pass", bus.oPass, 0);
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    repeat (4) @(posedge iClk);
    start_run(16'h0F0F, 1'b0);
    wait_done(n);
    check("t4_done_cycle", n, DONE_CYC);
    check("t4_pass", bus.oPass, 1);

    // iStart held: no restart while busy, DONE lasts one cycle, then a cleared rerun.
    flip[8'h10] = 16'h8000;
    start_run(16'h5555, 1'b1);
    wait_done(n);
    check("t5_done_cycle", n, DONE_CYC);
    check("t5_err", bus.oErrCount, INV ? 2 : 1);
    check("t5_fail", bus.oFailAddr, 8'h10);
    @(posedge iClk);
    #1;
    check("t5_restart_done", bus.oDone, 0);
    check("t5_restart_busy", bus.oBusy, 1);
    check("t5_restart_wr", bus.oWR, 1);
    check("t5_restart_addr", bus.oAddress, 0);
    check("t5_restart_err", bus.oErrCount, 0);
    bus.iStart = 1'b0;
    wait_done(n);
    check("t5_rerun_cycle", n, DONE_CYC);
    clear_faults();

`ifdef MEMSCAN_INVERSE_PASS_EN
    // Fault visible only on the inverted pass.
    flip[8'h20] = 16'h0004;
    fault_pass  = 2;
    start_run(16'h0000, 1'b0);
    wait_done(n);
    check("t6_done_cycle", n, 1027);
    check("t6_p2w0", p2w0_data, 16'hFFFF);
    check("t6_err", bus.oErrCount, 1);
    check("t6_fail", bus.oFailAddr, 8'h20);
    check("t6_pass", bus.oPass, 0);
    clear_faults();
`endif

    repeat (3) @(posedge iClk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
